// File: rtl/mono_rx_pkg.sv
// Shared types and helpers for the mono_data_rx readout mergers.
package mono_rx_pkg;

  localparam int unsigned MONO_WORD_W = 32;
  localparam int unsigned MONO_TAG_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mono_rr_pick.sv
// Combinational rotating-priority encoder: first set req bit at or after rr_ptr.
module mono_rr_pick
  import mono_rx_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  localparam int unsigned IDX_W = idx_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [IDX_W:0]    sum;

  assign req_dbl = {req, req};
  assign req_rot = N_CH'(req_dbl >> rr_ptr);

  // Scan the rotated vector, then map the offset back to an absolute index.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (!valid && req_rot[k]) begin
        valid = 1'b1;
        sum   = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(N_CH)) begin
          sum = sum - (IDX_W+1)'(N_CH);
        end
        idx = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/mono_rx_fifo_arbiter.sv
// Round-robin burst arbiter merging N_CH rx channel FIFOs into one FWFT stream.
// Optional MONO_ARB_TAG_EN replaces OUT_DATA[31:28] with the granted channel index.
module mono_rx_fifo_arbiter
  import mono_rx_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned BURST_MAX = 16,
  localparam int unsigned IDX_W    = idx_width(N_CH)
) (
  input  logic                        BUS_CLK,
  input  logic                        RST,
  input  logic [N_CH-1:0]             EN_MASK,
  input  logic [N_CH-1:0]             CH_EMPTY,
  input  logic [MONO_WORD_W*N_CH-1:0] CH_DATA,
  output logic [N_CH-1:0]             CH_READ,
  input  logic                        OUT_READ,
  output logic                        OUT_EMPTY,
  output logic [MONO_WORD_W-1:0]      OUT_DATA,
  output logic [IDX_W-1:0]            GRANT,
  output logic                        BUSY,
  output logic [15:0]                 BURST_DONE_CNT
);

  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

`ifdef MONO_ARB_TAG_EN
  if (N_CH > 16) begin : g_tag_range
    $error("mono_rx_fifo_arbiter: MONO_ARB_TAG_EN supports at most 16 channels");
  end
`endif

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [15:0]      done_cnt_q, done_cnt_d;

  logic [N_CH-1:0]        req_c;
  logic [IDX_W-1:0]       pick_idx_c;
  logic                   pick_valid_c;
  logic                   sel_empty_c;
  logic                   sel_en_c;
  logic [MONO_WORD_W-1:0] sel_word_c;
  logic [MONO_WORD_W-1:0] out_word_c;
  logic                   out_empty_c;
  logic                   pop_c;
  logic [IDX_W-1:0]       rr_next_c;

  assign req_c = ~CH_EMPTY & EN_MASK;

  mono_rr_pick #(
    .N_CH (N_CH)
  ) u_pick (
    .req    (req_c),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx_c),
    .valid  (pick_valid_c)
  );

  // Pass-through mux for the granted channel.
  always_comb begin
    sel_empty_c = 1'b1;
    sel_en_c    = 1'b0;
    sel_word_c  = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_empty_c = CH_EMPTY[i];
        sel_en_c    = EN_MASK[i];
        sel_word_c  = CH_DATA[i*MONO_WORD_W +: MONO_WORD_W];
      end
    end
  end

  always_comb begin
    out_word_c = sel_word_c;
`ifdef MONO_ARB_TAG_EN
    out_word_c[MONO_WORD_W-1 -: MONO_TAG_W] = MONO_TAG_W'(grant_q);
`endif
  end

  // A reset cycle never pops, even if the burst is still nominally active.
  assign out_empty_c = RST | (state_q != BURST) | sel_empty_c | ~sel_en_c;
  assign pop_c       = OUT_READ & ~out_empty_c;
  assign rr_next_c   = (grant_q == IDX_W'(N_CH - 1)) ? '0 : grant_q + IDX_W'(1);

  always_comb begin
    CH_READ = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      CH_READ[i] = pop_c & (grant_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    done_cnt_d  = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          grant_d     = pick_idx_c;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (pop_c) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        if ((pop_c && (burst_cnt_q == CNT_W'(BURST_MAX - 1))) || out_empty_c) begin
          state_d  = IDLE;
          rr_ptr_d = rr_next_c;
          if (done_cnt_q != 16'hFFFF) begin
            done_cnt_d = done_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign OUT_EMPTY      = out_empty_c;
  assign OUT_DATA       = out_word_c;
  assign GRANT          = grant_q;
  assign BUSY           = (state_q == BURST) & ~RST;
  assign BURST_DONE_CNT = done_cnt_q;

endmodule
